// File: rtl/sprite_raster_scheduler_if.sv
// Frame buffer write port of the sprite raster scheduler.
// A write moves on any cycle where fb_we and fb_ready are both high.
interface sprite_raster_scheduler_if #(
  parameter int COORD_W = 10
);
  logic               fb_we;
  logic [COORD_W-1:0] fb_x;
  logic [COORD_W-1:0] fb_y;
  logic [7:0]         fb_color;
  logic               fb_ready;

  modport master (
    output fb_we, fb_x, fb_y, fb_color,
    input  fb_ready
  );

  modport slave (
    input  fb_we, fb_x, fb_y, fb_color,
    output fb_ready
  );
endinterface

// File: rtl/sprite_raster_scheduler.sv
// Round-robin shared circle rasterizer: one bounding-box point per cycle,
// filled-circle pixels streamed to the frame buffer write port.
module sprite_raster_scheduler #(
  parameter int NUM_BALLS = 4,
  parameter int COORD_W   = 10,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_BALLS-1:0]         req,
  input  logic [NUM_BALLS*COORD_W-1:0] center_x,
  input  logic [NUM_BALLS*COORD_W-1:0] center_y,
  input  logic [NUM_BALLS*6-1:0]       radius,
  input  logic [NUM_BALLS*8-1:0]       color,
  output logic [NUM_BALLS-1:0]         grant,
  output logic [NUM_BALLS-1:0]         done,
  output logic                         busy,
  sprite_raster_scheduler_if.master    fb
);

  localparam int PW = $clog2(NUM_BALLS);
  localparam logic signed [COORD_W:0] XLIM =
    (COORD_W+1)'(SCREEN_W);
  localparam logic signed [COORD_W:0] YLIM =
    (COORD_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SCAN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]          ptr, sel, sel_q, cand;
  logic                   found;
  logic [NUM_BALLS-1:0]   sel_oh;
  logic [COORD_W-1:0]     cx, cy;
  logic [5:0]             rad;
  logic [7:0]             col;
  logic signed [6:0]      dx, dy, rad_s;
  logic [5:0]             adx, ady;
  logic [11:0]            sqx, sqy, r2;
  logic [12:0]            s;
  logic signed [COORD_W:0] dxe, dye, px, py;
  logic                   draw, stall, last;

  // First pending requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_BALLS);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign sel_oh = NUM_BALLS'(1) << sel_q;
  assign rad_s  = $signed({1'b0, rad});

  assign adx = dx[6] ? 6'(-dx) : dx[5:0];
  assign ady = dy[6] ? 6'(-dy) : dy[5:0];
  assign sqx = {6'd0, adx} * {6'd0, adx};
  assign sqy = {6'd0, ady} * {6'd0, ady};
  assign r2  = {6'd0, rad} * {6'd0, rad};
  assign s   = {1'b0, sqx} + {1'b0, sqy};

  assign dxe = {{(COORD_W-6){dx[6]}}, dx};
  assign dye = {{(COORD_W-6){dy[6]}}, dy};
  assign px  = $signed({1'b0, cx}) + dxe;
  assign py  = $signed({1'b0, cy}) + dye;

  assign draw = (s < {1'b0, r2})
              && !px[COORD_W] && (px < XLIM)
              && !py[COORD_W] && (py < YLIM);

  assign stall = fb.fb_we && !fb.fb_ready;
  assign last  = (dx == rad_s) && (dy == rad_s);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant   = '0;
    done    = '0;
    busy    = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (found) state_n = GRANT;
      end
      GRANT: begin
        grant   = sel_oh;
        state_n = SCAN;
      end
      SCAN: begin
        if (!stall && last) state_n = DONE;
      end
      DONE: begin
        done    = sel_oh;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr         <= '0;
      sel_q       <= '0;
      cx          <= '0;
      cy          <= '0;
      rad         <= '0;
      col         <= '0;
      dx          <= '0;
      dy          <= '0;
      fb.fb_we    <= 1'b0;
      fb.fb_x     <= '0;
      fb.fb_y     <= '0;
      fb.fb_color <= '0;
    end else begin
      if (state == IDLE && found) begin
        sel_q <= sel;
        ptr   <= PW'((int'(sel) + 1) % NUM_BALLS);
        cx    <= center_x[sel*COORD_W +: COORD_W];
        cy    <= center_y[sel*COORD_W +: COORD_W];
        rad   <= radius[sel*6 +: 6];
        col   <= color[sel*8 +: 8];
        dx    <= 7'sd0 - $signed({1'b0, radius[sel*6 +: 6]});
        dy    <= 7'sd0 - $signed({1'b0, radius[sel*6 +: 6]});
      end
      // A pending unaccepted write freezes both the port and the walk.
      if (state == SCAN && !stall) begin
        fb.fb_we <= draw;
        if (draw) begin
          fb.fb_x     <= px[COORD_W-1:0];
          fb.fb_y     <= py[COORD_W-1:0];
          fb.fb_color <= col;
        end
        if (dx == rad_s) begin
          dx <= 7'sd0 - rad_s;
          dy <= dy + 7'sd1;
        end else begin
          dx <= dx + 7'sd1;
        end
      end else if (state != SCAN) begin
        fb.fb_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sprite_raster_scheduler.md
Name: sprite_raster_scheduler

Overview:
Shares one sequential circle-rasterizer between NUM_BALLS ball requesters and writes each ball's filled-circle pixels into the frame buffer write port. A round-robin arbiter grants one requester at a time and latches its center, radius and color. The block then walks the (2r+1)x(2r+1) bounding box one point per cycle, using the same strict inside test as the sprite logic: dx²+dy² < r². It sits between the physics update and the frame buffer.

Parameters:
NUM_BALLS, 4, number of requesters (2..8)
COORD_W, 10, width of screen coordinates
SCREEN_W, 640, visible width; valid x is 0..SCREEN_W-1
SCREEN_H, 480, visible height; valid y is 0..SCREEN_H-1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_BALLS  per-requester draw request, level
center_x  in  NUM_BALLS*COORD_W  packed ball centers x, requester i at [i*COORD_W +: COORD_W]
center_y  in  NUM_BALLS*COORD_W  packed ball centers y
radius  in  NUM_BALLS*6  packed radii, 0..63
color  in  NUM_BALLS*8  packed colors
grant  out  NUM_BALLS  one-hot, one-cycle pulse when a requester is accepted
done  out  NUM_BALLS  one-hot, one-cycle pulse when that requester's sprite is complete
busy  out  1  high from the grant cycle through the done cycle
fb_we  out  1  frame buffer write valid
fb_x  out  COORD_W  write x
fb_y  out  COORD_W  write y
fb_color  out  8  write color
fb_ready  in  1  frame buffer accepts the write this cycle

Behaviour:
- Reset: all outputs are 0. State is IDLE. The round-robin pointer is 0, so requester 0 has highest priority first. Reset mid-scan aborts without a done pulse.
- State IDLE:
  - If any req bit is high in cycle k, select the first set bit starting at the pointer and wrapping modulo NUM_BALLS.
  - In cycle k+1: grant[sel]=1 and busy=1. The selected requester's center, radius and color, as sampled at the end of cycle k, are latched.
  - The pointer becomes sel+1 mod NUM_BALLS.
- State SCAN (entered at k+2):
  - dy runs -r..+r (outer loop), dx runs -r..+r (inner loop). dx and dy are signed 7-bit.
  - Each cycle evaluates one point: s = dx²+dy² (13-bit unsigned), compared with r² (12-bit unsigned).
  - x = center_x+dx and y = center_y+dy, computed as signed COORD_W+1 bits.
  - The point is drawn iff s < r², 0 <= x < SCREEN_W, and 0 <= y < SCREEN_H. Otherwise it is skipped with no write; a skipped point still costs one cycle.
  - A drawn point sets fb_we/fb_x/fb_y/fb_color on the next cycle (registered outputs).
- Backpressure:
  - A write is accepted when fb_we && fb_ready.
  - While fb_we=1 and fb_ready=0, fb_we/fb_x/fb_y/fb_color hold and the scan does not advance.
  - fb_ready is ignored when fb_we=0.
  - The stall-free scan takes exactly (2r+1)² evaluation cycles.
- State DONE:
  - Entered after the last write is accepted, or after the last point if it was skipped.
  - Lasts one cycle: done[sel]=1, busy=1, fb_we=0.
  - Next state is IDLE, so there is at least one non-busy IDLE cycle between jobs.
- Requests:
  - req is sampled only in IDLE.
  - Params of the granted requester are frozen after the grant; input changes during SCAN have no effect.
  - A req held high after done is re-arbitrated normally, behind other waiting requesters.
- r=0: one evaluation point, 0<0 is false, no writes; done follows.
- r=63: 127x127 box, matching the sprite extent.
- Simultaneous requests: strict round-robin; no requester waits more than NUM_BALLS-1 jobs.
- A deasserted req bit is never granted.

Test Plan:
- Reset, then req=0001 with ball0 at (100,100), r=1 -> grant=0001 one cycle after req; exactly one write (100,100,color0); scan is 9 cycles; done=0001; busy falls after done.
- Ball at (200,150), r=2, fb_ready=1 -> 9 writes covering x 199..201, y 149..151 in row-major order; (198,150) is never written; done after 25 scan cycles.
- r=3 at (320,240) -> 25 writes; (317,240) and (323,240) are absent because d²=9 is not < 9.
- Ball at (0,0), r=2 -> only 4 writes: (0,0), (1,0), (0,1), (1,1). The scan still takes 25 cycles.
- req=1111 held continuously from reset -> grant order 0,1,2,3,0; each grant arrives after the prior done plus one IDLE cycle. Then with r=0 on all balls -> no fb_we; done pulses follow the same order.
- r=2 job with fb_ready low for 3 cycles on the 2nd write -> fb_x/fb_y held stable; total writes still 9 with no duplicates. Assert reset mid-scan -> next cycle fb_we=0, busy=0, no done; afterwards the pointer restarts at requester 0.
